// File: rtl/af_focus_search_ctrl_pkg.sv
// Autofocus search shared types: FSM state, sweep phase, VCM write word builder
// and the default parameter set used by the controller, its interface and bench.
package af_pkg;

    localparam int unsigned POS_W_DEF         = 10;
    localparam int unsigned POS_MAX_DEF       = 1023;
    localparam int unsigned COARSE_STEP_DEF   = 32;
    localparam int unsigned FINE_STEP_DEF     = 4;
    localparam int unsigned SETTLE_FRAMES_DEF = 2;
    localparam int unsigned METRIC_W_DEF      = 24;
    localparam int unsigned VCM_DATA_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SETTLE,
        ST_MEASURE,
        ST_EVAL,
        ST_PARK,
        ST_DONE
    } af_state_e;

    typedef enum logic {
        PH_COARSE,
        PH_FINE
    } af_phase_e;

    // VCM driver word: position sits in bits [13:4]
    function automatic logic [VCM_DATA_W-1:0] vcm_word(input logic [POS_W_DEF-1:0] pos);
        return {2'b00, pos, 4'h0};
    endfunction

endpackage

// File: rtl/af_focus_search_ctrl_if.sv
// Autofocus controller bus: start key, frame statistics input, VCM I2C
// req/ack handshake and search status.
//   master : the search controller
//   slave  : key/statistics/I2C writer side
interface af_focus_search_ctrl_if
    import af_pkg::*;
#(
    parameter int unsigned POS_W    = POS_W_DEF,
    parameter int unsigned METRIC_W = METRIC_W_DEF
) ();
    logic                  AUTO_FOC;
    logic                  FRAME_END;
    logic [METRIC_W-1:0]   METRIC;
    logic                  I2C_ACK;
    logic                  I2C_REQ;
    logic [VCM_DATA_W-1:0] VCM_DATA;
    logic [POS_W-1:0]      VCM_POS;
    logic [METRIC_W-1:0]   BEST_METRIC;
    logic                  BUSY;
    logic                  VCM_END;

    modport master (
        input  AUTO_FOC, FRAME_END, METRIC, I2C_ACK,
        output I2C_REQ, VCM_DATA, VCM_POS, BEST_METRIC, BUSY, VCM_END
    );

    modport slave (
        output AUTO_FOC, FRAME_END, METRIC, I2C_ACK,
        input  I2C_REQ, VCM_DATA, VCM_POS, BEST_METRIC, BUSY, VCM_END
    );
endinterface

// File: rtl/af_focus_search_ctrl_peak_tracker.sv
// Running maximum of the sharpness metric and the lens position where it occurred.
//   clr     : zero best_metric/best_pos (new search)
//   cap_en  : present metric/pos for comparison this cycle
//   best_*  : registered peak; strictly-greater update so ties keep the earlier position
module af_peak_tracker #(
    parameter int unsigned POS_W    = 10,
    parameter int unsigned METRIC_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                cap_en,
    input  logic [METRIC_W-1:0] metric,
    input  logic [POS_W-1:0]    pos,
    output logic [METRIC_W-1:0] best_metric,
    output logic [POS_W-1:0]    best_pos
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_metric <= '0;
            best_pos    <= '0;
        end else if (clr) begin
            best_metric <= '0;
            best_pos    <= '0;
        end else if (cap_en && (metric > best_metric)) begin
            best_metric <= metric;
            best_pos    <= pos;
        end
    end

endmodule

// File: rtl/af_focus_search_ctrl.sv
// Autofocus sequencer: coarse then fine lens sweep, one sharpness metric per
// position after discarding settle frames, then parks the lens at the peak.
//   VIDEO_CLK : clock
//   RESET_N   : async active-low reset
//   bus       : start key, FRAME_END/METRIC, I2C_REQ/I2C_ACK, VCM_DATA/VCM_POS,
//               BEST_METRIC, BUSY, VCM_END
module af_focus_search_ctrl
    import af_pkg::*;
#(
    parameter int unsigned POS_W         = POS_W_DEF,
    parameter int unsigned POS_MAX       = POS_MAX_DEF,
    parameter int unsigned COARSE_STEP   = COARSE_STEP_DEF,
    parameter int unsigned FINE_STEP     = FINE_STEP_DEF,
    parameter int unsigned SETTLE_FRAMES = SETTLE_FRAMES_DEF,
    parameter int unsigned METRIC_W      = METRIC_W_DEF
) (
    input logic                      VIDEO_CLK,
    input logic                      RESET_N,
    af_focus_search_ctrl_if.master   bus
);

    localparam int unsigned CNT_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;

    af_state_e             state_q, state_d;
    af_phase_e             phase_q, phase_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [POS_W-1:0]      hi_q, hi_d;
    logic [CNT_W-1:0]      settle_q, settle_d;
    logic                  req_q, req_d;
    logic                  busy_q, busy_d;
    logic                  end_q, end_d;
    logic [METRIC_W-1:0]   best_out_q, best_out_d;
    logic [VCM_DATA_W-1:0] data_q, data_d;

    logic [2:0]            foc_sync;
    logic                  start_q;
    logic                  trk_clr, trk_cap;
    logic [METRIC_W-1:0]   best_metric;
    logic [POS_W-1:0]      best_pos;

    logic [POS_W:0]        step_c, nxt_c, hi_ext_c;
    logic [POS_W-1:0]      win_lo_c, win_hi_c;

    // Key synchroniser (idle high) and registered falling-edge start pulse
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            foc_sync <= 3'b111;
            start_q  <= 1'b0;
        end else begin
            foc_sync <= {foc_sync[1:0], bus.AUTO_FOC};
            start_q  <= foc_sync[2] & ~foc_sync[1];
        end
    end

    af_peak_tracker #(
        .POS_W    (POS_W),
        .METRIC_W (METRIC_W)
    ) u_peak (
        .clk         (VIDEO_CLK),
        .rst_n       (RESET_N),
        .clr         (trk_clr),
        .cap_en      (trk_cap),
        .metric      (bus.METRIC),
        .pos         (pos_q),
        .best_metric (best_metric),
        .best_pos    (best_pos)
    );

    // Next sweep point and fine window around the coarse peak, one bit wider to catch overflow
    always_comb begin
        step_c   = (phase_q == PH_COARSE) ? (POS_W+1)'(COARSE_STEP) : (POS_W+1)'(FINE_STEP);
        nxt_c    = {1'b0, pos_q} + step_c;
        hi_ext_c = {1'b0, best_pos} + (POS_W+1)'(COARSE_STEP);
        win_hi_c = (hi_ext_c > (POS_W+1)'(POS_MAX)) ? POS_W'(POS_MAX) : hi_ext_c[POS_W-1:0];
        win_lo_c = (best_pos >= POS_W'(COARSE_STEP)) ? (best_pos - POS_W'(COARSE_STEP)) : '0;
    end

    // State and output registers
    always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_COARSE;
            pos_q      <= '0;
            hi_q       <= '0;
            settle_q   <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            end_q      <= 1'b0;
            best_out_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            pos_q      <= pos_d;
            hi_q       <= hi_d;
            settle_q   <= settle_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            end_q      <= end_d;
            best_out_q <= best_out_d;
            data_q     <= data_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        pos_d      = pos_q;
        hi_d       = hi_q;
        settle_d   = settle_q;
        req_d      = req_q;
        busy_d     = busy_q;
        end_d      = end_q;
        best_out_d = best_out_q;
        trk_clr    = 1'b0;
        trk_cap    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    trk_clr    = 1'b1;
                    phase_d    = PH_COARSE;
                    pos_d      = '0;
                    hi_d       = POS_W'(POS_MAX);
                    end_d      = 1'b0;
                    busy_d     = 1'b1;
                    best_out_d = '0;
                    state_d    = ST_MOVE;
                end
            end
            // REQ is low on the entry cycle, so an ACK there is a stray and ignored
            ST_MOVE, ST_PARK: begin
                if (req_q && bus.I2C_ACK) begin
                    req_d    = 1'b0;
                    settle_d = '0;
                    if (state_q == ST_PARK) begin
                        state_d = ST_DONE;
                    end else if (SETTLE_FRAMES != 0) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (bus.FRAME_END) begin
                    if (settle_q == CNT_W'(SETTLE_FRAMES - 1)) begin
                        settle_d = '0;
                        state_d  = ST_MEASURE;
                    end else begin
                        settle_d = settle_q + CNT_W'(1);
                    end
                end
            end
            // Peak compare happens as the metric is captured, so EVAL sees the updated best
            ST_MEASURE: begin
                if (bus.FRAME_END) begin
                    trk_cap = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (nxt_c <= {1'b0, hi_q}) begin
                    pos_d   = nxt_c[POS_W-1:0];
                    state_d = ST_MOVE;
                end else if (phase_q == PH_COARSE) begin
                    phase_d = PH_FINE;
                    pos_d   = win_lo_c;
                    hi_d    = win_hi_c;
                    state_d = ST_MOVE;
                end else begin
                    pos_d   = best_pos;
                    state_d = ST_PARK;
                end
            end
            ST_DONE: begin
                end_d      = 1'b1;
                busy_d     = 1'b0;
                best_out_d = best_metric;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Position only changes on entry to MOVE/PARK, so the word follows it
        data_d = vcm_word(POS_W_DEF'(pos_d));
    end

    assign bus.I2C_REQ     = req_q;
    assign bus.VCM_DATA    = data_q;
    assign bus.VCM_POS     = pos_q;
    assign bus.BEST_METRIC = best_out_q;
    assign bus.BUSY        = busy_q;
    assign bus.VCM_END     = end_q;

endmodule

// File: tb/tb_af_focus_search_ctrl.sv
// Bench for af_focus_search_ctrl: frame/metric source and randomized-latency
// I2C responder around the DUT, expected sweep computed from the search rules.
module tb_af_focus_search_ctrl;
    import af_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    af_focus_search_ctrl_if bus ();

    af_focus_search_ctrl dut (
        .VIDEO_CLK (clk),
        .RESET_N   (rst_n),
        .bus       (bus)
    );

    int tests = 0;
    int fails = 0;

    // environment configuration
    int  peak        = 300;
    bit  flat        = 1'b0;
    bit  settle_junk = 1'b0;
    bit  ack_en      = 1'b1;
    int  frame_len   = 16;
    int  ack_max     = 4;
    int  stray_cnt   = 0;
    int  stray_done  = 0;
    int  fsa         = 100;
    int  frame_ctr   = 0;
    int  ack_wait    = 0;

    int unsigned hs_q[$];
    int unsigned exp_q[$];
    int unsigned exp_pos;
    int unsigned exp_best;

    function automatic int unsigned profile(input int p);
        int d;
        if (flat) return 500;
        d = (p > peak) ? (p - peak) : (peak - p);
        return 32'(100000 - 50 * d);
    endfunction

    // Expected sweep: coarse grid, fine window around coarse best, then park
    function automatic void model();
        int unsigned bm;
        int bp, lo, hi;
        bm = 0;
        bp = 0;
        exp_q.delete();
        for (int p = 0; p <= 1023; p += 32) begin
            exp_q.push_back(p);
            if (profile(p) > bm) begin bm = profile(p); bp = p; end
        end
        lo = (bp >= 32) ? bp - 32 : 0;
        hi = (bp + 32 > 1023) ? 1023 : bp + 32;
        for (int p = lo; p <= hi; p += 4) begin
            exp_q.push_back(p);
            if (profile(p) > bm) begin bm = profile(p); bp = p; end
        end
        exp_q.push_back(bp);
        exp_pos  = bp;
        exp_best = bm;
    endfunction

    // Frame source and I2C writer stand-in
    always @(negedge clk) begin
        frame_ctr++;
        if (frame_ctr >= frame_len) begin
            frame_ctr     = 0;
            bus.FRAME_END = 1'b1;
            bus.METRIC    = (settle_junk && fsa < 2) ? 24'hFFFFFF : 24'(profile(int'(bus.VCM_POS)));
            fsa++;
        end else begin
            bus.FRAME_END = 1'b0;
        end
        if (stray_cnt != stray_done) begin
            stray_done  = stray_cnt;
            bus.I2C_ACK = 1'b1;
        end else if (ack_en && bus.I2C_REQ === 1'b1 && bus.I2C_ACK !== 1'b1) begin
            if (ack_wait == 0) begin
                bus.I2C_ACK = 1'b1;
                fsa         = 0;
                ack_wait    = int'($urandom_range(ack_max, 0));
            end else begin
                ack_wait--;
                bus.I2C_ACK = 1'b0;
            end
        end else begin
            bus.I2C_ACK = 1'b0;
        end
    end

    // Log every completed handshake's position
    always @(posedge clk) begin
        if (rst_n && bus.I2C_REQ === 1'b1 && bus.I2C_ACK === 1'b1)
            hs_q.push_back(int'(bus.VCM_POS));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_start();
        @(negedge clk);
        bus.AUTO_FOC = 1'b0;
        repeat (6) @(negedge clk);
        bus.AUTO_FOC = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.VCM_END !== 1'b1 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_in_time"}, 32'(n < 30000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_checks(input string tag);
        int bad = 0;
        int n;
        check({tag, "_hs_count"}, 32'(hs_q.size()), 32'(exp_q.size()));
        n = (hs_q.size() < exp_q.size()) ? hs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (hs_q[i] !== exp_q[i]) bad++;
        check({tag, "_pos_sequence"}, 32'(bad), 32'd0);
        check({tag, "_vcm_pos"}, 32'(bus.VCM_POS), exp_pos);
        check({tag, "_vcm_data"}, 32'(bus.VCM_DATA), 32'(vcm_word(10'(exp_pos))));
        check({tag, "_best_metric"}, 32'(bus.BEST_METRIC), exp_best);
        check({tag, "_vcm_end"}, 32'(bus.VCM_END), 32'd1);
        check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_req_idle"}, 32'(bus.I2C_REQ), 32'd0);
    endtask

    task automatic run_search(input string tag);
        model();
        hs_q.delete();
        press_start();
        wait_done(tag);
        finish_checks(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, 32'(bus.I2C_REQ), 32'd0);
        check({tag, "_pos"}, 32'(bus.VCM_POS), 32'd0);
        check({tag, "_data"}, 32'(bus.VCM_DATA), 32'd0);
        check({tag, "_best"}, 32'(bus.BEST_METRIC), 32'd0);
        check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_end"}, 32'(bus.VCM_END), 32'd0);
    endtask

    initial begin
        logic [15:0] data0;
        int          stall_bad;
        int          n;

        rst_n        = 1'b0;
        bus.AUTO_FOC = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // parabolic peak at 300
        peak = 300;
        run_search("peak300");
        check("peak300_hs_50", 32'(hs_q.size()), 32'd50);
        check("peak300_data_12c0", 32'(bus.VCM_DATA), 32'h12C0);
        check("peak300_best_100000", 32'(bus.BEST_METRIC), 32'd100000);

        // stray ACK while idle
        stray_cnt++;
        repeat (4) @(negedge clk);
        check("stray_ack_req", 32'(bus.I2C_REQ), 32'd0);
        check("stray_ack_busy", 32'(bus.BUSY), 32'd0);
        check("stray_ack_end", 32'(bus.VCM_END), 32'd1);

        // edge clamp near zero
        peak = 5;
        run_search("edge5");
        check("edge5_final_4", 32'(bus.VCM_POS), 32'd4);

        // flat metric, ties keep position 0
        flat = 1'b1;
        run_search("flat");
        check("flat_best_500", 32'(bus.BEST_METRIC), 32'd500);
        flat = 1'b0;

        // settle frames carry junk that must be discarded
        peak        = 300;
        settle_junk = 1'b1;
        run_search("settle");
        check("settle_final_300", 32'(bus.VCM_POS), 32'd300);
        settle_junk = 1'b0;

        // randomized peaks, frame periods and ACK latency
        for (int r = 0; r < 3; r++) begin
            peak      = int'($urandom_range(1023, 0));
            frame_len = int'($urandom_range(24, 6));
            ack_max   = int'($urandom_range(8, 0));
            run_search($sformatf("rand%0d_pk%0d", r, peak));
        end
        frame_len = 16;
        ack_max   = 4;

        // stalled ACK: REQ and data hold, frames ignored
        peak   = 300;
        ack_en = 1'b0;
        model();
        hs_q.delete();
        press_start();
        n = 0;
        while (bus.I2C_REQ !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("stall_req_rise", 32'(bus.I2C_REQ), 32'd1);
        data0     = bus.VCM_DATA;
        stall_bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.I2C_REQ !== 1'b1 || bus.VCM_DATA !== data0 || bus.BUSY !== 1'b1) stall_bad++;
        end
        check("stall_steady", 32'(stall_bad), 32'd0);
        check("stall_no_hs", 32'(hs_q.size()), 32'd0);
        check("stall_pos0", 32'(bus.VCM_POS), 32'd0);
        ack_en = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            #1;
            if (bus.I2C_ACK === 1'b1) break;
            n++;
        end
        check("stall_ack_seen", 32'(bus.I2C_ACK), 32'd1);
        @(posedge clk);
        #1;
        check("stall_req_drop", 32'(bus.I2C_REQ), 32'd0);
        wait_done("stall");
        finish_checks("stall");

        // second start during the search is ignored
        model();
        hs_q.delete();
        press_start();
        repeat (300) @(negedge clk);
        check("restart_busy", 32'(bus.BUSY), 32'd1);
        press_start();
        wait_done("restart");
        finish_checks("restart");

        // start after DONE: VCM_END holds through the pulse, clears the cycle after
        model();
        hs_q.delete();
        @(negedge clk);
        bus.AUTO_FOC = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("end_hold_at_pulse", 32'(bus.VCM_END), 32'd1);
        @(posedge clk);
        #1;
        check("end_clear_after_pulse", 32'(bus.VCM_END), 32'd0);
        check("busy_after_pulse", 32'(bus.BUSY), 32'd1);
        repeat (3) @(negedge clk);
        bus.AUTO_FOC = 1'b1;

        // reset in the fine sweep aborts asynchronously
        n = 0;
        while (hs_q.size() < 40 && n < 30000) begin @(negedge clk); n++; end
        check("midfine_reached", 32'(hs_q.size() >= 40), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_idle_busy", 32'(bus.BUSY), 32'd0);
        check("post_reset_idle_req", 32'(bus.I2C_REQ), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/af_focus_search_ctrl.md
Name: af_focus_search_ctrl

Overview:
- Autofocus sequencer in the video clock domain.
- On a start command it drives the VCM lens position through a coarse sweep and then a fine sweep, one frame sharpness metric per position, tracking the best position.
- It parks the lens at the peak and raises VCM_END.
- It issues each position to the existing VCM I2C writer through a req/ack handshake and consumes the per-frame sharpness sum from the pixel statistics path.

Parameters:
- POS_W, 10, VCM position width.
- POS_MAX, 1023, highest legal position.
- COARSE_STEP, 32, coarse sweep increment.
- FINE_STEP, 4, fine sweep increment; fine window is best_coarse ± COARSE_STEP.
- SETTLE_FRAMES, 2, frames discarded after each lens move.
- METRIC_W, 24, sharpness metric width.

Ports:
- VIDEO_CLK, in, 1, sole clock.
- RESET_N, in, 1, asynchronous active-low reset.
- AUTO_FOC, in, 1, active-low start key (synchronised internally); start fires on its 1->0 transition.
- FRAME_END, in, 1, one-cycle pulse at end of each frame; METRIC is valid in that cycle.
- METRIC, in, METRIC_W, frame sharpness sum.
- I2C_ACK, in, 1, one-cycle pulse: VCM write complete.
- I2C_REQ, out, 1, VCM write request.
- VCM_DATA, out, 16, write word {2'b00, pos[9:0], 4'h0}.
- VCM_POS, out, POS_W, current commanded position.
- BEST_METRIC, out, METRIC_W, peak metric found.
- BUSY, out, 1, search in progress.
- VCM_END, out, 1, search complete, lens parked at peak.

Behaviour:
- Reset values: I2C_REQ=0, VCM_POS=0, VCM_DATA=0, BEST_METRIC=0, BUSY=0, VCM_END=0, state=IDLE.
- Reset mid-search aborts immediately; no I2C_REQ is held across reset.
- AUTO_FOC passes through a 2-flop synchroniser, then an edge detector. The start pulse is one cycle and lands 3 cycles after the pin falls.
- States: IDLE, MOVE, SETTLE, MEASURE, EVAL, PARK, DONE.
- IDLE: on start, clear best_metric=0, best_pos=0, phase=COARSE, pos=0, VCM_END=0, BUSY=1 -> MOVE.
- MOVE:
  - I2C_REQ rises the cycle after entry and holds until the cycle I2C_ACK is sampled high; REQ falls the next cycle.
  - VCM_DATA/VCM_POS change only on entry to MOVE and are stable while REQ=1.
  - On ACK: go to SETTLE if SETTLE_FRAMES>0, else MEASURE.
  - I2C_ACK while REQ=0 is ignored.
- SETTLE: count FRAME_END pulses; after SETTLE_FRAMES pulses -> MEASURE.
- MEASURE: on next FRAME_END capture METRIC -> EVAL.
- EVAL (1 cycle):
  - If metric > best_metric (strict; ties keep the earlier position), update best_metric/best_pos.
  - Next position = pos + step (COARSE_STEP or FINE_STEP), computed in POS_W+1 bits.
  - If next position ≤ phase upper limit: pos=next -> MOVE.
  - Else if phase=COARSE: phase=FINE, lo = best_pos - COARSE_STEP clamped at 0, hi = best_pos + COARSE_STEP clamped at POS_MAX, pos=lo -> MOVE.
  - Else -> PARK.
  - Coarse upper limit is POS_MAX.
- PARK: pos=best_pos, run the MOVE handshake, then DONE.
- DONE: VCM_END=1, BUSY=0, BEST_METRIC=best_metric -> IDLE. VCM_END holds until the next start.
- Start pulse while BUSY=1: ignored.
- FRAME_END during MOVE: ignored, so a frame straddling a move is never measured.
- FRAME_END coincident with state entry into SETTLE/MEASURE: not counted.
- All comparisons are unsigned.

Decomposition:
- Package af_pkg:
  - state enum.
  - phase enum (COARSE/FINE).
  - function vcm_word(pos) building VCM_DATA.
  - default parameter constants.
- One sub-module, af_peak_tracker: registered best_metric/best_pos with clear, strict-greater compare, and capture enable.

Test Plan:
- Parabolic peak: METRIC = 100000 − 50·|pos−300|; start.
  - Expect coarse positions 0,32,…,992 (32 points), coarse best 288.
  - Expect fine positions 256..320 step 4 (17 points).
  - Final VCM_POS=300, VCM_DATA=16'h12C0, BEST_METRIC=100000, VCM_END=1.
  - Expect 50 I2C_REQ handshakes in total.
- Handshake: hold I2C_ACK low for 1000 cycles.
  - Expect I2C_REQ steady high and VCM_DATA unchanged.
  - Expect FRAME_ENDs ignored and no state advance.
  - On ACK, REQ drops next cycle.
  - A stray ACK with REQ=0 has no effect.
- Edge clamp: peak at pos 5.
  - Fine window 0..32.
  - Final VCM_POS=4 (nearest fine point); no position below 0 or above 1023 is ever issued.
- Ties and flat metric: METRIC constant 500.
  - best_pos stays 0 (strict compare); fine window 0..32.
  - Final VCM_POS=0, BEST_METRIC=500.
- Settle discard: SETTLE_FRAMES=2, METRIC on the first two frames after each ACK = 24'hFFFFFF, else peak profile.
  - Result is identical to the parabolic-peak case (300), proving settle frames are discarded.
- Reset/restart:
  - Assert RESET_N low mid-fine-sweep: all outputs return to reset values asynchronously.
  - A second start while BUSY=1 is ignored.
  - A start after DONE clears VCM_END the cycle after the start pulse.
